lut_sweep_ctrl: RTL and testbench
=================================

// Module: lut_sweep_ctrl
// PURPOSE
//  Sequencer for a combinational WIDTH-input, 1-output lookup table.
//  - Sweep mode: on a start request, drives every input code 0..2^WIDTH-1 into the LUT, one per cycle.
//    It collects the result as a hit bitmap, a hit count, and the first and last hit codes.
//  - Single mode: looks up one code for a requester, using a req/ack handshake.
//  Sits between a control/test master and the LUT. The LUT attaches via lut_x_o/lut_y_i.
// PARAMETERS
//  WIDTH   4   LUT input width; DEPTH = 2**WIDTH codes
// PORTS
//  clk_i        in   1      system clock, rising edge
//  rst_ni       in   1      asynchronous reset, active low
//  start_i      in   1      sweep request; sampled only in IDLE
//  req_i        in   1      single-lookup request; level, held until ack_o
//  req_x_i      in   WIDTH  code for single lookup; stable while req_i=1
//  ack_o        out  1      1-cycle pulse: single lookup finished, hit_o valid
//  hit_o        out  1      registered LUT result of the last single lookup
//  lut_x_o      out  WIDTH  code driven to LUT (registered)
//  lut_y_i      in   1      LUT output for lut_x_o (combinational, same cycle)
//  busy_o       out  1      1 in any state other than IDLE
//  done_o       out  1      1-cycle pulse at sweep end; results valid from this cycle
//  hit_map_o    out  DEPTH  bit k = LUT(k), from the last completed sweep
//  hit_cnt_o    out  WIDTH+1  number of hits in the last sweep (0..DEPTH)
//  first_hit_o  out  WIDTH  lowest hit code; 0 when hit_cnt_o=0
//  last_hit_o   out  WIDTH  highest hit code; 0 when hit_cnt_o=0
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state IDLE; every output and register is 0.
//  - States: IDLE, SWEEP, DRAIN, SINGLE, DONE.
//  - IDLE:
//    - start_i=1 -> SWEEP, cnt=0, clear the sweep accumulators.
//    - else req_i=1 -> SINGLE, lut_x_o<=req_x_i.
//    - start_i and req_i both 1 -> the sweep wins. req stays pending and is served after the sweep.
//  - SWEEP: lut_x_o<=cnt each cycle and cnt increments.
//    - lut_y_i is registered together with its code: ypipe, xpipe (1-cycle pipe).
//    - When ypipe=1: set hit_map[xpipe], increment hit_cnt, set last_hit=xpipe.
//    - first_hit is written on the first hit only.
//    - After code DEPTH-1 is issued (cnt wrap) -> DRAIN. cnt is WIDTH bits and wraps to 0.
//  - DRAIN: accumulates the final pipe entry (code DEPTH-1) -> DONE.
//  - DONE: done_o=1 for exactly one cycle; results update atomically at this edge -> IDLE.
//  - Latency: start seen at edge 0 -> done_o high at edge DEPTH+2 (18 cycles for WIDTH=4).
//  - Result outputs keep their values until the next DONE. A new sweep does not disturb them
//    mid-run, because it uses shadow accumulators.
//  - SINGLE: one cycle with lut_x_o applied. It samples hit_o<=lut_y_i, pulses ack_o, -> IDLE.
//    - Total latency is 2 cycles from req accepted to ack_o.
//    - The requester drops req_i after ack_o. req_i still high in the cycle after ack starts a new lookup.
//  - start_i outside IDLE is ignored: no queuing, no restart.
//  - Reset mid-sweep aborts. Results return to 0 and no done_o pulse is produced.
//  - lut_x_o holds its last value in IDLE.
// STRUCTURE
//  - Package lut_ctrl_pkg holds:
//    - typedef enum logic [2:0] state_t {IDLE, SWEEP, DRAIN, SINGLE, DONE}
//    - function clog/depth helpers
//  - One sub-module: lut_hit_tracker.
//    - Inputs: valid, x, y, clear, commit.
//    - It owns the shadow bitmap, count, and first/last registers plus the output copy.
//  - The controller FSM plus cnt live in lut_sweep_ctrl; the LUT stays outside the block.
//  - Sequential logic: always_ff @(posedge clk_i or negedge rst_ni). Next-state logic in always_comb with defaults.
// TESTING (WIDTH=4, LUT true for codes 4, 8, 10)
//  1. Reset held 3 cycles, then released -> all outputs 0, busy_o=0.
//  2. start_i pulse -> busy_o=1, done_o 18 cycles later.
//     hit_map_o=16'h0510, hit_cnt_o=3, first_hit_o=4, last_hit_o=10.
//  3. req_i with req_x_i=8 -> ack_o 2 cycles later with hit_o=1.
//     Then req_x_i=9 -> hit_o=0. Sweep results unchanged.
//  4. start_i and req_i(x=10) in the same cycle -> full sweep first. ack_o (hit_o=1) 2 cycles after done_o.
//  5. start_i re-pulsed mid-sweep -> ignored, still exactly one done_o. A second sweep gives identical results.
//  6. rst_ni low at sweep cycle 7 -> outputs 0 immediately, no done_o.
//     A fresh sweep afterwards gives test-2 values.
//     LUT model forced all-zero -> hit_cnt_o=0, first_hit_o=0, last_hit_o=0.

Source files
------------

// File: rtl/lut_ctrl_pkg.sv
// Shared types and elaboration helpers for the LUT sweep controller.
package lut_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    DRAIN  = 3'd2,
    SINGLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int lut_depth(input int width);
    return 32'sd1 << width;
  endfunction

  function automatic int lut_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << r) < value) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_hit_tracker.sv
// Shadow accumulator for one sweep (bitmap, count, first/last hit) and the
// published result copy that only changes on commit.
module lut_hit_tracker
  import lut_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int DEPTH = lut_depth(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid,
  input  logic [WIDTH-1:0]   x,
  input  logic               y,
  input  logic               clear,
  input  logic               commit,
  output logic [DEPTH-1:0]   hit_map,
  output logic [WIDTH:0]     hit_cnt,
  output logic [WIDTH-1:0]   first_hit,
  output logic [WIDTH-1:0]   last_hit
);

  logic [DEPTH-1:0] map_r, map_s;
  logic [WIDTH:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0] first_r, first_s;
  logic [WIDTH-1:0] last_r, last_s;
  logic             found_r, found_s;

  // Next shadow values; commit publishes these so the final pipe entry lands in the same edge
  always_comb begin
    map_s   = map_r;
    cnt_s   = cnt_r;
    first_s = first_r;
    last_s  = last_r;
    found_s = found_r;
    if (clear) begin
      map_s   = {DEPTH{1'b0}};
      cnt_s   = {(WIDTH+1){1'b0}};
      first_s = {WIDTH{1'b0}};
      last_s  = {WIDTH{1'b0}};
      found_s = 1'b0;
    end else if (valid && y) begin
      map_s[x] = 1'b1;
      cnt_s    = cnt_r + {{WIDTH{1'b0}}, 1'b1};
      last_s   = x;
      found_s  = 1'b1;
      if (!found_r) begin
        first_s = x;
      end else begin
        first_s = first_r;
      end
    end else begin
      map_s = map_r;
    end
  end

  // Shadow and published result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_r     <= {DEPTH{1'b0}};
      cnt_r     <= {(WIDTH+1){1'b0}};
      first_r   <= {WIDTH{1'b0}};
      last_r    <= {WIDTH{1'b0}};
      found_r   <= 1'b0;
      hit_map   <= {DEPTH{1'b0}};
      hit_cnt   <= {(WIDTH+1){1'b0}};
      first_hit <= {WIDTH{1'b0}};
      last_hit  <= {WIDTH{1'b0}};
    end else begin
      map_r   <= map_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
      last_r  <= last_s;
      found_r <= found_s;
      if (commit) begin
        hit_map   <= map_s;
        hit_cnt   <= cnt_s;
        first_hit <= first_s;
        last_hit  <= last_s;
      end
    end
  end

endmodule

// File: rtl/lut_sweep_ctrl.sv
// Sequencer for an external WIDTH-input LUT: full-range sweep with hit
// statistics, or a single req/ack lookup.
module lut_sweep_ctrl
  import lut_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int DEPTH = lut_depth(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               req_i,
  input  logic [WIDTH-1:0]   req_x_i,
  output logic               ack_o,
  output logic               hit_o,
  output logic [WIDTH-1:0]   lut_x_o,
  input  logic               lut_y_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [DEPTH-1:0]   hit_map_o,
  output logic [WIDTH:0]     hit_cnt_o,
  output logic [WIDTH-1:0]   first_hit_o,
  output logic [WIDTH-1:0]   last_hit_o
);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r;
  logic             issued_r;
  logic             vld_r;
  logic [WIDTH-1:0] xpipe_r;
  logic             ypipe_r;
  logic             clear_s;
  logic             commit_s;

  // Next-state selection; a simultaneous start wins and leaves req pending
  always_comb begin
    state_s  = state_r;
    clear_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = SWEEP;
          clear_s = 1'b1;
        end else if (req_i) begin
          state_s = SINGLE;
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        if (&cnt_r) begin
          state_s = DRAIN;
        end else begin
          state_s = SWEEP;
        end
      end
      DRAIN:   state_s = DONE;
      SINGLE:  state_s = IDLE;
      DONE: begin
        state_s  = IDLE;
        commit_s = 1'b1;
      end
      default: state_s = IDLE;
    endcase
  end

  // Controller state, code counter, y/x pipe and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      cnt_r    <= {WIDTH{1'b0}};
      issued_r <= 1'b0;
      vld_r    <= 1'b0;
      xpipe_r  <= {WIDTH{1'b0}};
      ypipe_r  <= 1'b0;
      ack_o    <= 1'b0;
      hit_o    <= 1'b0;
      lut_x_o  <= {WIDTH{1'b0}};
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_r  <= state_s;
      busy_o   <= (state_s != IDLE);
      done_o   <= commit_s;
      ack_o    <= (state_r == SINGLE);
      // A pipe entry is valid one cycle after a sweep code was put on lut_x_o
      issued_r <= (state_r == SWEEP);
      vld_r    <= issued_r;
      xpipe_r  <= lut_x_o;
      ypipe_r  <= lut_y_i;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            cnt_r <= {WIDTH{1'b0}};
          end else if (req_i) begin
            lut_x_o <= req_x_i;
          end
        end
        SWEEP: begin
          lut_x_o <= cnt_r;
          cnt_r   <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        SINGLE:  hit_o <= lut_y_i;
        default: ;
      endcase
    end
  end

  lut_hit_tracker #(.WIDTH(WIDTH)) u_tracker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid     (vld_r),
    .x         (xpipe_r),
    .y         (ypipe_r),
    .clear     (clear_s),
    .commit    (commit_s),
    .hit_map   (hit_map_o),
    .hit_cnt   (hit_cnt_o),
    .first_hit (first_hit_o),
    .last_hit  (last_hit_o)
  );

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Directed bench for lut_sweep_ctrl with WIDTH=4 and a behavioural LUT.
module tb_lut_sweep_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst_ni;
  logic             start_i;
  logic             req_i;
  logic [WIDTH-1:0] req_x_i;
  logic             ack_o;
  logic             hit_o;
  logic [WIDTH-1:0] lut_x_o;
  logic             lut_y_i;
  logic             busy_o;
  logic             done_o;
  logic [DEPTH-1:0] hit_map_o;
  logic [WIDTH:0]   hit_cnt_o;
  logic [WIDTH-1:0] first_hit_o;
  logic [WIDTH-1:0] last_hit_o;

  int n_checks;
  int n_errors;
  int lut_mode;  // 0: hits at 4/8/10, 1: all zero, 2: all one

  lut_sweep_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .req_i       (req_i),
    .req_x_i     (req_x_i),
    .ack_o       (ack_o),
    .hit_o       (hit_o),
    .lut_x_o     (lut_x_o),
    .lut_y_i     (lut_y_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hit_map_o   (hit_map_o),
    .hit_cnt_o   (hit_cnt_o),
    .first_hit_o (first_hit_o),
    .last_hit_o  (last_hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (lut_mode == 1) begin
      lut_y_i = 1'b0;
    end else if (lut_mode == 2) begin
      lut_y_i = 1'b1;
    end else begin
      lut_y_i = (lut_x_o == 4'd4) || (lut_x_o == 4'd8) || (lut_x_o == 4'd10);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done_o after the start edge; optionally re-pulses start at edge repulse_at
  task automatic wait_done(input int repulse_at, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      start_i = (c == repulse_at);
      tick();
      if (done_o) begin
        lat = c;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (done_o) pulses = pulses + 1;
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] map, input int cnt,
                               input int first, input int last);
    check({tag, "_map"},   32'(hit_map_o),   32'(map));
    check({tag, "_cnt"},   32'(hit_cnt_o),   cnt);
    check({tag, "_first"}, 32'(first_hit_o), first);
    check({tag, "_last"},  32'(last_hit_o),  last);
  endtask

  task automatic single(input logic [3:0] x, input logic exp_hit, input string tag);
    req_i   = 1'b1;
    req_x_i = x;
    tick();
    check({tag, "_busy"}, 32'(busy_o), 1);
    check({tag, "_ack_early"}, 32'(ack_o), 0);
    tick();
    check({tag, "_ack"}, 32'(ack_o), 1);
    check({tag, "_hit"}, 32'(hit_o), 32'(exp_hit));
    req_i = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 32'(ack_o), 0);
  endtask

  int lat;
  int pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    lut_mode = 0;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    req_i    = 1'b0;
    req_x_i  = 4'd0;

    // 1. reset
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_ack",  32'(ack_o), 0);
    check("rst_hit",  32'(hit_o), 0);
    check("rst_lutx", 32'(lut_x_o), 0);
    check_results("rst", 16'h0000, 0, 0, 0);

    // 2. basic sweep
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("sw_busy", 32'(busy_o), 1);
    check("sw_done_early", 32'(done_o), 0);
    check_results("sw_hold", 16'h0000, 0, 0, 0);
    wait_done(0, lat);
    check("sw_latency", lat, 18);
    check_results("sw", 16'h0510, 3, 4, 10);
    tick();
    check("sw_done_pulse", 32'(done_o), 0);
    check("sw_busy_end", 32'(busy_o), 0);

    // 3. single lookups
    single(4'd8, 1'b1, "s8");
    single(4'd9, 1'b0, "s9");
    check_results("after_single", 16'h0510, 3, 4, 10);

    // 4. start and req together: sweep first, then lookup
    start_i = 1'b1;
    req_i   = 1'b1;
    req_x_i = 4'd10;
    tick();
    start_i = 1'b0;
    wait_done(0, lat);
    check("both_latency", lat, 18);
    check("both_ack_at_done", 32'(ack_o), 0);
    tick();
    check("both_ack_early", 32'(ack_o), 0);
    tick();
    check("both_ack", 32'(ack_o), 1);
    check("both_hit", 32'(hit_o), 1);
    check("both_lutx", 32'(lut_x_o), 10);
    req_i = 1'b0;
    tick();

    // 5. start re-pulsed mid-sweep is ignored
    start_i = 1'b1;
    tick();
    wait_done(5, lat);
    check("repulse_latency", lat, 18);
    check_results("repulse", 16'h0510, 3, 4, 10);
    count_done(25, pulses);
    check("repulse_extra_done", pulses, 0);

    // 6. reset mid-sweep aborts
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (7) tick();
    rst_ni = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 0);
    check("abort_lutx", 32'(lut_x_o), 0);
    check_results("abort", 16'h0000, 0, 0, 0);
    tick();
    rst_ni = 1'b1;
    count_done(25, pulses);
    check("abort_no_done", pulses, 0);

    start_i = 1'b1;
    tick();
    wait_done(0, lat);
    check("fresh_latency", lat, 18);
    check_results("fresh", 16'h0510, 3, 4, 10);
    tick();

    lut_mode = 1;
    start_i  = 1'b1;
    tick();
    wait_done(0, lat);
    check("zero_latency", lat, 18);
    check_results("zero", 16'h0000, 0, 0, 0);
    tick();

    lut_mode = 2;
    start_i  = 1'b1;
    tick();
    wait_done(0, lat);
    check("full_latency", lat, 18);
    check_results("full", 16'hFFFF, 16, 0, 15);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
